// File: rtl/exec_decoder.sv
// exec_decoder: instruction decode and execute-phase sequencer for the
// 8-bit SAP processor. Latches the fetched instruction, reports the last
// execute step of the latched opcode, drives per-step datapath controls
// combinationally, and holds the carry/zero flags and the halt state.
module exec_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_complete,
    input  logic [1:0] step,
    input  logic [7:0] ir,
    input  logic       carry_in,
    input  logic       zero_in,
    output logic [1:0] steps_required,
    output logic [7:0] operand,
    output logic       ir_out,
    output logic       a_out,
    output logic       alu_out,
    output logic       mar_load,
    output logic       ram_read,
    output logic       ram_write,
    output logic       a_load,
    output logic       b_load,
    output logic       alu_sub,
    output logic       pc_load,
    output logic       out_load,
    output logic       carry_flag,
    output logic       zero_flag,
    output logic       halt
);

    // Opcode encodings (9..D are unassigned and decode as NOP).
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions inside the packed control word.
    localparam int unsigned B_IR_OUT    = 10;
    localparam int unsigned B_A_OUT     = 9;
    localparam int unsigned B_ALU_OUT   = 8;
    localparam int unsigned B_MAR_LOAD  = 7;
    localparam int unsigned B_RAM_READ  = 6;
    localparam int unsigned B_RAM_WRITE = 5;
    localparam int unsigned B_A_LOAD    = 4;
    localparam int unsigned B_B_LOAD    = 3;
    localparam int unsigned B_ALU_SUB   = 2;
    localparam int unsigned B_PC_LOAD   = 1;
    localparam int unsigned B_OUT_LOAD  = 0;

    // Last execute step index for each opcode.
    function automatic logic [1:0] last_step(input logic [3:0] op);
        logic [1:0] res;
        case (op)
            OP_LDA:  res = 2'd1;
            OP_ADD:  res = 2'd2;
            OP_SUB:  res = 2'd2;
            OP_STA:  res = 2'd1;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    logic [3:0]  op_r;
    logic [3:0]  opd_r;
    logic        carry_r;
    logic        zero_r;
    logic        halt_r;

    logic [10:0] ucode_s;
    logic [10:0] ctrl_s;
    logic [1:0]  steps_s;
    logic        active_s;
    logic        flag_capture_s;
    logic        halt_set_s;

    assign active_s       = fetch_complete & ~halt_r;
    assign flag_capture_s = active_s & ((op_r == OP_ADD) | (op_r == OP_SUB)) & (step == 2'd2);
    assign halt_set_s     = active_s & (op_r == OP_HLT) & (step == 2'd0);

    // Instruction latch: track IR during fetch, hold through execute and halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r  <= 4'h0;
            opd_r <= 4'h0;
        end else if (!fetch_complete && !halt_r) begin
            op_r  <= ir[7:4];
            opd_r <= ir[3:0];
        end
    end

    // ALU flags: captured only at the end of ADD/SUB step 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
        end else if (flag_capture_s) begin
            carry_r <= carry_in;
            zero_r  <= zero_in;
        end
    end

    // Sticky halt register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_r <= 1'b0;
        end else if (halt_set_s) begin
            halt_r <= 1'b1;
        end
    end

    // Microcode ROM: ungated control word for the latched opcode and step.
    always_comb begin
        ucode_s = 11'd0;
        case (op_r)
            OP_LDA: begin
                case (step)
                    2'd0: begin
                        ucode_s[B_IR_OUT]   = 1'b1;
                        ucode_s[B_MAR_LOAD] = 1'b1;
                    end
                    2'd1: begin
                        ucode_s[B_RAM_READ] = 1'b1;
                        ucode_s[B_A_LOAD]   = 1'b1;
                    end
                    default: ucode_s = 11'd0;
                endcase
            end
            OP_ADD, OP_SUB: begin
                case (step)
                    2'd0: begin
                        ucode_s[B_IR_OUT]   = 1'b1;
                        ucode_s[B_MAR_LOAD] = 1'b1;
                    end
                    2'd1: begin
                        ucode_s[B_RAM_READ] = 1'b1;
                        ucode_s[B_B_LOAD]   = 1'b1;
                        ucode_s[B_ALU_SUB]  = (op_r == OP_SUB);
                    end
                    2'd2: begin
                        ucode_s[B_ALU_OUT]  = 1'b1;
                        ucode_s[B_A_LOAD]   = 1'b1;
                        ucode_s[B_ALU_SUB]  = (op_r == OP_SUB);
                    end
                    default: ucode_s = 11'd0;
                endcase
            end
            OP_STA: begin
                case (step)
                    2'd0: begin
                        ucode_s[B_IR_OUT]   = 1'b1;
                        ucode_s[B_MAR_LOAD] = 1'b1;
                    end
                    2'd1: begin
                        ucode_s[B_A_OUT]     = 1'b1;
                        ucode_s[B_RAM_WRITE] = 1'b1;
                    end
                    default: ucode_s = 11'd0;
                endcase
            end
            OP_LDI: begin
                if (step == 2'd0) begin
                    ucode_s[B_IR_OUT] = 1'b1;
                    ucode_s[B_A_LOAD] = 1'b1;
                end else begin
                    ucode_s = 11'd0;
                end
            end
            OP_JMP: begin
                if (step == 2'd0) begin
                    ucode_s[B_IR_OUT]  = 1'b1;
                    ucode_s[B_PC_LOAD] = 1'b1;
                end else begin
                    ucode_s = 11'd0;
                end
            end
            OP_JC: begin
                if ((step == 2'd0) && carry_r) begin
                    ucode_s[B_IR_OUT]  = 1'b1;
                    ucode_s[B_PC_LOAD] = 1'b1;
                end else begin
                    ucode_s = 11'd0;
                end
            end
            OP_JZ: begin
                if ((step == 2'd0) && zero_r) begin
                    ucode_s[B_IR_OUT]  = 1'b1;
                    ucode_s[B_PC_LOAD] = 1'b1;
                end else begin
                    ucode_s = 11'd0;
                end
            end
            OP_OUT: begin
                if (step == 2'd0) begin
                    ucode_s[B_A_OUT]    = 1'b1;
                    ucode_s[B_OUT_LOAD] = 1'b1;
                end else begin
                    ucode_s = 11'd0;
                end
            end
            // NOP, HLT and the unassigned opcodes drive nothing; HLT acts
            // through the halt register instead.
            default: ucode_s = 11'd0;
        endcase
    end

    // Gate the control word outside execute and while halted.
    always_comb begin
        ctrl_s = 11'd0;
        if (active_s) begin
            ctrl_s = ucode_s;
        end else begin
            ctrl_s = 11'd0;
        end
    end

    // Step count reported to the fetch controller; collapses to 0 when halted.
    always_comb begin
        steps_s = 2'd0;
        if (halt_r) begin
            steps_s = 2'd0;
        end else begin
            steps_s = last_step(op_r);
        end
    end

    assign steps_required = steps_s;
    assign operand        = {4'h0, opd_r};
    assign ir_out         = ctrl_s[B_IR_OUT];
    assign a_out          = ctrl_s[B_A_OUT];
    assign alu_out        = ctrl_s[B_ALU_OUT];
    assign mar_load       = ctrl_s[B_MAR_LOAD];
    assign ram_read       = ctrl_s[B_RAM_READ];
    assign ram_write      = ctrl_s[B_RAM_WRITE];
    assign a_load         = ctrl_s[B_A_LOAD];
    assign b_load         = ctrl_s[B_B_LOAD];
    assign alu_sub        = ctrl_s[B_ALU_SUB];
    assign pc_load        = ctrl_s[B_PC_LOAD];
    assign out_load       = ctrl_s[B_OUT_LOAD];
    assign carry_flag     = carry_r;
    assign zero_flag      = zero_r;
    assign halt           = halt_r;

endmodule

// File: tb/tb_exec_decoder.sv
// Directed self-checking bench for exec_decoder.
module tb_exec_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_complete;
    logic [1:0] step;
    logic [7:0] ir;
    logic       carry_in;
    logic       zero_in;
    logic [1:0] steps_required;
    logic [7:0] operand;
    logic       ir_out, a_out, alu_out, mar_load, ram_read, ram_write;
    logic       a_load, b_load, alu_sub, pc_load, out_load;
    logic       carry_flag, zero_flag, halt;

    int pass_count  = 0;
    int check_count = 0;

    localparam logic [10:0] IRO  = 11'h400;
    localparam logic [10:0] AO   = 11'h200;
    localparam logic [10:0] ALUO = 11'h100;
    localparam logic [10:0] MARL = 11'h080;
    localparam logic [10:0] RAMR = 11'h040;
    localparam logic [10:0] RAMW = 11'h020;
    localparam logic [10:0] AL   = 11'h010;
    localparam logic [10:0] BL   = 11'h008;
    localparam logic [10:0] SUBM = 11'h004;
    localparam logic [10:0] PCL  = 11'h002;
    localparam logic [10:0] OUTL = 11'h001;

    wire [10:0] ctrl = {ir_out, a_out, alu_out, mar_load, ram_read, ram_write,
                        a_load, b_load, alu_sub, pc_load, out_load};
    wire [3:0]  bus  = {ir_out, a_out, alu_out, ram_read};

    exec_decoder dut (
        .clk(clk), .rst(rst), .fetch_complete(fetch_complete), .step(step),
        .ir(ir), .carry_in(carry_in), .zero_in(zero_in),
        .steps_required(steps_required), .operand(operand),
        .ir_out(ir_out), .a_out(a_out), .alu_out(alu_out), .mar_load(mar_load),
        .ram_read(ram_read), .ram_write(ram_write), .a_load(a_load),
        .b_load(b_load), .alu_sub(alu_sub), .pc_load(pc_load),
        .out_load(out_load), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction during fetch, then enter execute at step 0.
    task automatic fetch(input logic [7:0] v);
        fetch_complete = 1'b0;
        step = 2'd0;
        ir = v;
        tick();
        fetch_complete = 1'b1;
        step = 2'd0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_complete = 1'b1; step = 2'd0; ir = 8'hF0;
        carry_in = 1'b1; zero_in = 1'b1;
        tick();
        check_count++;
        if (ctrl !== 11'd0) $display("FAIL reset_ctrl: got %h expected %h", ctrl, 11'd0);
        else pass_count++;
        check_count++;
        if ({steps_required, carry_flag, zero_flag, halt} !== 5'b0)
            $display("FAIL reset_state: got steps=%0d c=%b z=%b h=%b expected all 0",
                     steps_required, carry_flag, zero_flag, halt);
        else pass_count++;
        rst = 1'b0; fetch_complete = 1'b0; carry_in = 1'b0; zero_in = 1'b0;
        tick();
    endtask

    task automatic test_ldi();
        // Controls stay low during fetch even with LDI latched.
        fetch_complete = 1'b0; ir = 8'h57; tick();
        check_count++;
        if (ctrl !== 11'd0) $display("FAIL fetch_gate: got %h expected %h", ctrl, 11'd0);
        else pass_count++;
        fetch(8'h57);
        check_count++;
        if (steps_required !== 2'd0) $display("FAIL ldi_steps: got %0d expected 0", steps_required);
        else pass_count++;
        check_count++;
        if (ctrl !== (IRO | AL)) $display("FAIL ldi_s0: got %h expected %h", ctrl, IRO | AL);
        else pass_count++;
        check_count++;
        if (operand !== 8'h07) $display("FAIL ldi_operand: got %h expected %h", operand, 8'h07);
        else pass_count++;
        tick();
    endtask

    task automatic test_add();
        carry_in = 1'b0; zero_in = 1'b0;
        fetch(8'h2A);
        check_count++;
        if (steps_required !== 2'd2) $display("FAIL add_steps: got %0d expected 2", steps_required);
        else pass_count++;
        check_count++;
        if (ctrl !== (IRO | MARL) || operand !== 8'h0A)
            $display("FAIL add_s0: got %h/%h expected %h/%h", ctrl, operand, IRO | MARL, 8'h0A);
        else pass_count++;
        tick(); step = 2'd1; #1;
        check_count++;
        if (ctrl !== (RAMR | BL)) $display("FAIL add_s1: got %h expected %h", ctrl, RAMR | BL);
        else pass_count++;
        tick(); step = 2'd2; carry_in = 1'b1; zero_in = 1'b1; #1;
        check_count++;
        if (ctrl !== (ALUO | AL)) $display("FAIL add_s2: got %h expected %h", ctrl, ALUO | AL);
        else pass_count++;
        check_count++;
        if ({carry_flag, zero_flag} !== 2'b00)
            $display("FAIL add_flags_pre: got %b expected %b", {carry_flag, zero_flag}, 2'b00);
        else pass_count++;
        tick();
        check_count++;
        if ({carry_flag, zero_flag} !== 2'b11)
            $display("FAIL add_flags: got %b expected %b", {carry_flag, zero_flag}, 2'b11);
        else pass_count++;
        carry_in = 1'b0; zero_in = 1'b0;
    endtask

    task automatic test_cond_jumps();
        fetch(8'h3F);
        check_count++;
        if (ctrl !== (IRO | MARL)) $display("FAIL sub_s0: got %h expected %h", ctrl, IRO | MARL);
        else pass_count++;
        tick(); step = 2'd1; #1;
        check_count++;
        if (ctrl !== (RAMR | BL | SUBM)) $display("FAIL sub_s1: got %h expected %h", ctrl, RAMR | BL | SUBM);
        else pass_count++;
        tick(); step = 2'd2; carry_in = 1'b0; zero_in = 1'b1; #1;
        check_count++;
        if (ctrl !== (ALUO | AL | SUBM)) $display("FAIL sub_s2: got %h expected %h", ctrl, ALUO | AL | SUBM);
        else pass_count++;
        tick();
        check_count++;
        if ({carry_flag, zero_flag} !== 2'b01)
            $display("FAIL sub_flags: got %b expected %b", {carry_flag, zero_flag}, 2'b01);
        else pass_count++;
        zero_in = 1'b0;
        fetch(8'h73);
        check_count++;
        if (ctrl !== 11'd0) $display("FAIL jc_not_taken: got %h expected %h", ctrl, 11'd0);
        else pass_count++;
        tick();
        fetch(8'h83);
        check_count++;
        if (ctrl !== (IRO | PCL) || operand !== 8'h03)
            $display("FAIL jz_taken: got %h/%h expected %h/%h", ctrl, operand, IRO | PCL, 8'h03);
        else pass_count++;
        tick();
    endtask

    task automatic test_misc_ops();
        fetch(8'h4C);
        check_count++;
        if (steps_required !== 2'd1 || ctrl !== (IRO | MARL))
            $display("FAIL sta_s0: got %0d/%h expected 1/%h", steps_required, ctrl, IRO | MARL);
        else pass_count++;
        tick(); step = 2'd1; #1;
        check_count++;
        if (ctrl !== (AO | RAMW)) $display("FAIL sta_s1: got %h expected %h", ctrl, AO | RAMW);
        else pass_count++;
        tick();
        fetch(8'h69);
        check_count++;
        if (ctrl !== (IRO | PCL)) $display("FAIL jmp_s0: got %h expected %h", ctrl, IRO | PCL);
        else pass_count++;
        tick();
        fetch(8'hE0);
        check_count++;
        if (ctrl !== (AO | OUTL)) $display("FAIL out_s0: got %h expected %h", ctrl, AO | OUTL);
        else pass_count++;
        tick();
    endtask

    task automatic test_latch_hold();
        fetch(8'h15);
        ir = 8'hF0; #1;
        check_count++;
        if (steps_required !== 2'd1 || ctrl !== (IRO | MARL) || operand !== 8'h05)
            $display("FAIL hold_s0: got %0d/%h/%h expected 1/%h/05", steps_required, ctrl, operand, IRO | MARL);
        else pass_count++;
        tick(); step = 2'd1; #1;
        check_count++;
        if (ctrl !== (RAMR | AL)) $display("FAIL hold_s1: got %h expected %h", ctrl, RAMR | AL);
        else pass_count++;
        tick(); step = 2'd2; #1;
        check_count++;
        if (ctrl !== 11'd0) $display("FAIL unused_step: got %h expected %h", ctrl, 11'd0);
        else pass_count++;
        check_count++;
        if (halt !== 1'b0) $display("FAIL hold_halt: got %b expected 0", halt);
        else pass_count++;
        fetch_complete = 1'b0; step = 2'd0; ir = 8'h00; tick();
    endtask

    task automatic test_halt();
        fetch(8'hF0);
        check_count++;
        if (halt !== 1'b0 || ctrl !== 11'd0)
            $display("FAIL hlt_s0: got h=%b ctrl=%h expected h=0 ctrl=000", halt, ctrl);
        else pass_count++;
        tick();
        check_count++;
        if (halt !== 1'b1) $display("FAIL halt_rise: got %b expected 1", halt);
        else pass_count++;
        fetch(8'h2A);
        step = 2'd1; carry_in = 1'b1; zero_in = 1'b0; #1;
        check_count++;
        if (ctrl !== 11'd0 || steps_required !== 2'd0 || halt !== 1'b1)
            $display("FAIL halted_ctrl: got %h/%0d/%b expected 000/0/1", ctrl, steps_required, halt);
        else pass_count++;
        tick(); step = 2'd2; #1; tick();
        check_count++;
        if ({carry_flag, zero_flag} !== 2'b01)
            $display("FAIL halted_flags: got %b expected %b", {carry_flag, zero_flag}, 2'b01);
        else pass_count++;
        rst = 1'b1; tick(); rst = 1'b0; fetch_complete = 1'b0; step = 2'd0;
        check_count++;
        if ({halt, carry_flag, zero_flag} !== 3'b000)
            $display("FAIL halt_reset: got %b expected %b", {halt, carry_flag, zero_flag}, 3'b000);
        else pass_count++;
        carry_in = 1'b0;
        tick();
    endtask

    task automatic test_bus_exclusivity();
        logic [3:0] opv;
        for (int op = 0; op < 16; op++) begin
            opv = op[3:0];
            // Seed random flags through an ADD.
            fetch(8'h21);
            tick(); step = 2'd1; tick(); step = 2'd2;
            carry_in = 1'($urandom_range(0, 1));
            zero_in  = 1'($urandom_range(0, 1));
            tick();
            fetch({opv, 4'($urandom_range(0, 15))});
            for (int s = 0; s < 4; s++) begin
                step = s[1:0]; #1;
                check_count++;
                if (!$onehot0(bus)) $display("FAIL bus_excl op=%h s=%0d: got %b expected at most one", opv, s, bus);
                else pass_count++;
                if (opv >= 4'h9 && opv <= 4'hD) begin
                    check_count++;
                    if (ctrl !== 11'd0 || steps_required !== 2'd0)
                        $display("FAIL unassigned op=%h s=%0d: got %h/%0d expected 000/0", opv, s, ctrl, steps_required);
                    else pass_count++;
                end
                tick();
            end
        end
        rst = 1'b1; tick(); rst = 1'b0; fetch_complete = 1'b0; step = 2'd0; tick();
    endtask

    initial begin
        rst = 1'b0; fetch_complete = 1'b0; step = 2'd0; ir = 8'h00;
        carry_in = 1'b0; zero_in = 1'b0;
        tick();
        test_reset();
        test_ldi();
        test_add();
        test_cond_jumps();
        test_misc_ops();
        test_latch_hold();
        test_halt();
        test_bus_exclusivity();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion expected finish before 500000");
        $fatal(1);
    end

endmodule

// File: doc/exec_decoder.md
# exec_decoder

Instruction decode and execute-phase sequencer for the 8-bit SAP processor. It sits directly downstream of the fetch controller and the instruction register. It latches the fetched instruction, returns the execute step count the controller needs, and drives the per-step datapath control signals. It also holds the carry/zero flags and the halt state.

## Interface

Parameters: none (8-bit datapath, 4-bit opcode, 4-bit operand).

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `fetch_complete` in 1: from controller; high during execute phase.
- `step` in 2: execute step index from controller.
- `ir` in 8: instruction register contents; `[7:4]` is the opcode, `[3:0]` is the operand.
- `carry_in` in 1: ALU carry, combinational from ALU.
- `zero_in` in 1: ALU zero, combinational from ALU.
- `steps_required` out 2: last step index of the latched opcode; the controller ends execute when `step == steps_required`.
- `operand` out 8: `{4'b0, latched operand}`; valid while `ir_out` is high.
- `ir_out` out 1: operand drives bus.
- `a_out` out 1: A register drives bus.
- `alu_out` out 1: ALU drives bus.
- `mar_load` out 1: load MAR from bus.
- `ram_read` out 1: RAM drives bus.
- `ram_write` out 1: RAM writes bus at MAR.
- `a_load` out 1: load A register.
- `b_load` out 1: load B register.
- `alu_sub` out 1: ALU subtract select.
- `pc_load` out 1: load PC from bus.
- `out_load` out 1: load output register.
- `carry_flag` out 1: registered carry flag.
- `zero_flag` out 1: registered zero flag.
- `halt` out 1: processor halted; the top level gates the clock enable with it.

## Operation

- **Latch:** while `fetch_complete == 0`, each edge captures `op_r <= ir[7:4]` and `opd_r <= ir[3:0]`. While `fetch_complete == 1`, both hold. The edge on which the controller raises `fetch_complete` still captures, so the final IR value is used.
- **Combinational outputs:** `steps_required` and all control outputs are combinational from `op_r`, `opd_r`, `step`, `fetch_complete`, `carry_flag`, `zero_flag` and `halt`.
- **Gating:** control outputs are 0 whenever `fetch_complete == 0` or `halt == 1`.
- **Microcode** (step: asserted signals; `steps_required` in brackets):
  - 0 NOP [0]: s0 none.
  - 1 LDA [1]: s0 `ir_out` + `mar_load`; s1 `ram_read` + `a_load`.
  - 2 ADD [2]: s0 `ir_out` + `mar_load`; s1 `ram_read` + `b_load`; s2 `alu_out` + `a_load`, flags capture.
  - 3 SUB [2]: same as ADD, with `alu_sub` also asserted in s1 and s2.
  - 4 STA [1]: s0 `ir_out` + `mar_load`; s1 `a_out` + `ram_write`.
  - 5 LDI [0]: s0 `ir_out` + `a_load`.
  - 6 JMP [0]: s0 `ir_out` + `pc_load`.
  - 7 JC [0]: s0 `ir_out` + `pc_load` only if `carry_flag`; otherwise nothing.
  - 8 JZ [0]: s0 `ir_out` + `pc_load` only if `zero_flag`; otherwise nothing.
  - E OUT [0]: s0 `a_out` + `out_load`.
  - F HLT [0]: s0 sets the halt register.
  - 9–D: treated as NOP [0].
- **Unused steps:** any step greater than the opcode's last step asserts nothing.
- **Flags:** on an edge with `fetch_complete`, not halted, `op_r` = ADD/SUB and `step == 2`, capture `carry_flag <= carry_in` and `zero_flag <= zero_in`. Flags hold at all other times.
- **Halt:** set on the edge with `fetch_complete`, `op_r == F` and `step == 0`. It is sticky until `rst`. While halted, `steps_required = 0` and the latch and flags freeze.
- **Bus invariant:** at most one of `ir_out`, `a_out`, `alu_out`, `ram_read` is high in any cycle.

## Timing

- **Reset values:** `rst` forces `op_r = 0`, `opd_r = 0`, `carry_flag = 0`, `zero_flag = 0`, `halt = 0` at the next edge. All control outputs are then 0 and `steps_required = 0`. `rst` overrides every other update in the same cycle.
- **Output latency:** zero cycles. Outputs are valid in the same cycle `step` and `fetch_complete` change, so datapath loads occur on the edge ending that step.
- **Execute length:** `steps_required + 1` cycles per instruction (e.g. ADD takes 3).
- **Flag visibility:** flags captured at the end of ADD step 2 are visible to a JC/JZ in the immediately following instruction.
- **Halt timing:** `halt` rises on the edge ending HLT step 0. From the next cycle, all controls are 0.
- **Reset mid-execute:** `rst` asserted during the execute phase clears everything. Controls drop once `fetch_complete` drops (the controller resets in the same edge).

## Test plan

1. **Reset and LDI:** reset, then `ir = 8'h57` and fetch. Expect `steps_required = 0`, and at step 0 `ir_out = a_load = 1` with `operand = 8'h07`. No other control high.
2. **ADD sequence:** `ir = 8'h2A`. Expect `steps_required = 2`. s0 `ir_out` + `mar_load` with `operand = 8'h0A`; s1 `ram_read` + `b_load`; s2 `alu_out` + `a_load`. With `carry_in = 1`, `zero_in = 1` at s2, expect `carry_flag = zero_flag = 1` after the edge.
3. **Conditional jumps:** SUB with `carry_in = 0`, `zero_in = 1` at s2 (`alu_sub` high in s1 and s2), then `ir = 8'h73` (JC) gives `pc_load = 0`, then `ir = 8'h83` (JZ) gives `pc_load = 1` with `operand = 8'h03`.
4. **Latch hold:** change `ir` to `8'hF0` during the LDA execute phase. Decoding stays LDA (`steps_required = 1`, s1 `ram_read` + `a_load`); `halt` stays 0.
5. **Halt:** `ir = 8'hF0`. `halt` rises after step 0 and stays 1 across later fetches of any `ir`, with all controls 0. Asserting `rst` clears `halt` and the flags to 0.
6. **Bus exclusivity:** run all 16 opcodes across steps 0–3 with random flags. The bus-driver exclusivity holds every cycle, and opcodes 9–D assert nothing.
